// File: rtl/debounce_if.sv
// debounce_if: groups the push-button conditioner signals.
//   btn_raw       raw pin (driven by the pin side / master)
//   btn_level     debounced state, 1 = pressed
//   press_pulse   one-cycle strobe on accepted press
//   release_pulse one-cycle strobe on accepted release
//   long_pulse    one-cycle strobe on long hold
// Modports: master = pin/consumer side, slave = debounce block.
interface debounce_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/debounce.sv
// debounce: synchronises a raw push-button pin into clk, rejects contact
// bounce with a stability counter and produces a clean level plus
// single-cycle press/release strobes. Optional long-press strobe is built
// when DEBOUNCE_LONG_PRESS_EN is defined; otherwise long_pulse is 0.
// Ports:
//   clk   system clock
//   nrst  synchronous active-low reset
//   bus   debounce_if.slave (btn_raw in; btn_level, press_pulse,
//         release_pulse, long_pulse out, all registered)
//
// state       | meaning
// ------------+-------------------------------------------------
// RELEASED    | button accepted as released, waiting for a press
// PRESS_CHK   | press seen, counting stable cycles before accepting
// PRESSED     | button accepted as pressed, waiting for a release
// RELEASE_CHK | release seen, counting stable cycles before accepting
module debounce #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic     clk,
  input  logic     nrst,
  debounce_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          s1, s2;
  logic          pressed;
  logic          level_q, press_q, release_q;
  logic          level_nxt, press_nxt, release_nxt;

  assign pressed = s2 ^ ACTIVE_LOW;

  // state register, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1        <= ACTIVE_LOW;
      s2        <= ACTIVE_LOW;
      state     <= RELEASED;
      cnt       <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1        <= bus.btn_raw;
      s2        <= s1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
    end
  end

  // next state; a bounce drops back and the next check restarts from 0
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (pressed) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!pressed)            state_nxt = RELEASED;
        else if (cnt == CNT_MAX) state_nxt = PRESSED;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      PRESSED: begin
        if (!pressed) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (pressed)             state_nxt = PRESSED;
        else if (cnt == CNT_MAX) state_nxt = RELEASED;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = RELEASED;
    endcase
  end

  // outputs change only on an accepted transition out of a CHK state
  always_comb begin
    level_nxt   = level_q;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (state == PRESS_CHK && state_nxt == PRESSED) begin
      level_nxt = 1'b1;
      press_nxt = 1'b1;
    end
    if (state == RELEASE_CHK && state_nxt == RELEASED) begin
      level_nxt   = 1'b0;
      release_nxt = 1'b1;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          long_q, long_nxt;

  // hold counter saturates at HOLD_MAX so long_pulse fires once per press,
  // and it keeps running through a rejected release bounce
  always_comb begin
    hcnt_nxt = hcnt;
    long_nxt = 1'b0;
    if (press_nxt || state_nxt == RELEASED) begin
      hcnt_nxt = '0;
    end else if ((state == PRESSED || state == RELEASE_CHK) && hcnt != HOLD_MAX) begin
      hcnt_nxt = hcnt + 1'b1;
      long_nxt = (hcnt_nxt == HOLD_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hcnt   <= '0;
      long_q <= 1'b0;
    end else begin
      hcnt   <= hcnt_nxt;
      long_q <= long_nxt;
    end
  end

  assign bus.long_pulse = long_q;
`else
  logic unused_long_cycles;
  assign unused_long_cycles = ^LONG_CYCLES;
  assign bus.long_pulse     = 1'b0;
`endif
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: directed and randomized checks of debounce against a
// run-length reference model (a change is accepted once the FSM has seen
// DEBOUNCE_CYCLES+1 consecutive samples opposite to the current level).
module tb_debounce;
  localparam int D = 4;
  localparam int L = 20;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk;
  logic nrst;
  int   vectors;
  int   miscompares;

  // reference model state
  logic m_s1, m_s2, m_level;
  int   m_run, m_since;
  logic [3:0] m_exp;

  debounce_if bus ();

  debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (level,press,release,long)", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1    = 1'b1;
    m_s2    = 1'b1;
    m_level = 1'b0;
    m_run   = 0;
    m_since = 0;
    m_exp   = 4'b0000;
  endtask

  // one clock: drive raw, advance model at the edge, compare 1 time unit later
  task automatic step(input logic raw);
    logic p, e_press, e_rel, e_long;
    bus.btn_raw = raw;
    @(posedge clk);
    if (!nrst) begin
      model_reset();
    end else begin
      p       = ~m_s2;
      m_s2    = m_s1;
      m_s1    = raw;
      e_press = 1'b0;
      e_rel   = 1'b0;
      e_long  = 1'b0;
      if (p != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = p;
          m_run   = 0;
          m_since = 0;
          if (p) e_press = 1'b1;
          else   e_rel   = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      if (LONG_EN && m_level && !e_press && m_since < L) begin
        m_since++;
        if (m_since == L) e_long = 1'b1;
      end
      m_exp = {m_level, e_press, e_rel, e_long};
    end
    #1;
    chk("model", obs(), m_exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    nrst        = 1'b0;
    bus.btn_raw = 1'b1;

    // reset with pin idle, then 50 quiet cycles
    repeat (3) step(1'b1);
    chk("reset_state", obs(), 4'b0000);
    nrst = 1'b1;
    repeat (50) step(1'b1);

    // clean press held 38 edges: press at edge 6, long at edge 26
    for (int i = 0; i < 38; i++) begin
      step(1'b0);
      if (i == 5)  chk("press_e5",  obs(), 4'b0000);
      if (i == 6)  chk("press_e6",  obs(), 4'b1100);
      if (i == 7)  chk("press_e7",  obs(), 4'b1000);
      if (i == 25) chk("long_e25",  obs(), 4'b1000);
      if (i == 26) chk("long_e26",  obs(), {3'b100, LONG_EN});
      if (i == 27) chk("long_e27",  obs(), 4'b1000);
    end
    // release: strobe 6 edges after the release edge
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      if (i == 5) chk("release_e5", obs(), 4'b1000);
      if (i == 6) chk("release_e6", obs(), 4'b0010);
      if (i == 7) chk("release_e7", obs(), 4'b0000);
    end

    // press bounce: low 3, high 2, low 3, then high
    repeat (3) step(1'b0);
    repeat (2) step(1'b1);
    repeat (3) step(1'b0);
    repeat (12) step(1'b1);
    chk("bounce_no_press", obs(), 4'b0000);

    // release bounce of 2 cycles while pressed; long timing unchanged
    for (int i = 0; i < 36; i++) begin
      step((i == 12 || i == 13) ? 1'b1 : 1'b0);
      if (i == 6)  chk("rb_press_e6", obs(), 4'b1100);
      if (i == 20) chk("rb_level",    obs(), 4'b1000);
      if (i == 26) chk("rb_long_e26", obs(), {3'b100, LONG_EN});
    end
    repeat (10) step(1'b1);

    // reset mid-press: no release strobe, fresh press 6 edges after release
    repeat (12) step(1'b0);
    chk("pre_reset_level", obs(), 4'b1000);
    nrst = 1'b0;
    step(1'b0);
    chk("mid_reset", obs(), 4'b0000);
    nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (i == 5) chk("repress_e5", obs(), 4'b0000);
      if (i == 6) chk("repress_e6", obs(), 4'b1100);
    end
    repeat (10) step(1'b1);

    // randomized runs of random length, occasional reset
    for (int r = 0; r < 200; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = (r % 17 == 5) ? int'($urandom_range(20, 30)) : int'($urandom_range(1, 8));
      if ($urandom_range(0, 49) == 0) begin
        nrst = 1'b0;
        step(v);
        nrst = 1'b1;
      end
      repeat (len) step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
